// File: rtl/subcarrier_burst_scheduler.sv
// -----------------------------------------------------------------------------
// subcarrier_burst_scheduler
//
// Sequences the colour subcarrier NCO for composite / S-video encoding.
// Owns the NCO phase increment. Frequency and PAL-alternation changes are
// taken through a one-deep pending slot and applied only at frame start, so
// the NCO always restarts at phase 0 with the new frequency. Also produces the
// per-line colour-burst gate and the PAL V-switch (line_flip).
//
// Ports
//   clk            system clock (74.25 MHz)
//   rst_n          asynchronous active-low reset
//   enable         scheduler run enable
//   hsync_start    one-cycle pulse at line start
//   vsync_start    one-cycle pulse at frame start
//   cfg_valid      new configuration offered
//   cfg_ready      pending slot free (registered)
//   cfg_phase_inc  requested NCO increment
//   cfg_pal_alt    requested PAL line alternation enable
//   phase_inc      NCO phase increment (registered)
//   nco_rst        one-cycle NCO restart pulse at frame start (registered)
//   burst_gate     colour-burst window (registered)
//   line_flip      PAL V-switch, 0 = +135 deg, 1 = -135 deg (registered)
//
// Line FSM
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | disabled or no line seen yet; waiting for hsync_start
//   WAIT_BURST | counting from line start up to BURST_START
//   BURST      | burst_gate high, counting to BURST_START+BURST_LEN
//   ACTIVE     | rest of the line; counter parked, waiting for hsync_start
// -----------------------------------------------------------------------------
module subcarrier_burst_scheduler #(
    parameter int unsigned BURST_START     = 393,
    parameter int unsigned BURST_LEN       = 187,
    parameter logic [31:0] PHASE_INC_RESET = 32'd207078536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        hsync_start,
    input  logic        vsync_start,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_phase_inc,
    input  logic        cfg_pal_alt,
    output logic [31:0] phase_inc,
    output logic        nco_rst,
    output logic        burst_gate,
    output logic        line_flip
);

    // The line counter holds "cycles since the hsync edge", so the burst
    // starts when it equals BURST_START and ends when it equals the sum.
    localparam logic [15:0] BURST_START_C = 16'(BURST_START);
    localparam logic [15:0] BURST_END_C   = 16'(BURST_START + BURST_LEN);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BURST = 2'd1,
        BURST      = 2'd2,
        ACTIVE     = 2'd3
    } state_t;

    state_t      state_q,          state_d;
    logic [15:0] cnt_q,            cnt_d;
    logic [31:0] phase_inc_q,      phase_inc_d;
    logic        pal_alt_q,        pal_alt_d;
    logic        nco_rst_q,        nco_rst_d;
    logic        burst_gate_q,     burst_gate_d;
    logic        line_flip_q,      line_flip_d;
    logic        cfg_ready_q,      cfg_ready_d;
    logic        pend_valid_q,     pend_valid_d;
    logic [31:0] pend_phase_inc_q, pend_phase_inc_d;
    logic        pend_pal_alt_q,   pend_pal_alt_d;

    logic cfg_xfer;
    logic frame_evt;
    logic line_evt;

    always_comb begin
        cfg_xfer  = cfg_valid && cfg_ready_q;
        frame_evt = enable && vsync_start;
        line_evt  = enable && hsync_start;

        state_d          = state_q;
        cnt_d            = cnt_q;
        phase_inc_d      = phase_inc_q;
        pal_alt_d        = pal_alt_q;
        burst_gate_d     = burst_gate_q;
        line_flip_d      = line_flip_q;
        pend_valid_d     = pend_valid_q;
        pend_phase_inc_d = pend_phase_inc_q;
        pend_pal_alt_d   = pend_pal_alt_q;

        // Frame boundary: commit the pending config together with the NCO
        // restart so the new frequency starts from phase 0.
        nco_rst_d = frame_evt;
        if (frame_evt && pend_valid_q) begin
            phase_inc_d  = pend_phase_inc_q;
            pal_alt_d    = pend_pal_alt_q;
            pend_valid_d = 1'b0;
        end

        // A transfer only happens while the slot is empty, so it can never
        // collide with the commit above; a config taken in a vsync cycle
        // therefore waits for the next frame.
        if (cfg_xfer) begin
            pend_valid_d     = 1'b1;
            pend_phase_inc_d = cfg_phase_inc;
            pend_pal_alt_d   = cfg_pal_alt;
        end
        cfg_ready_d = !pend_valid_d;

        // Toggle uses the pal_alt in force for the current frame; a vsync in
        // the same cycle wins and starts the frame on the +135 deg line.
        if (frame_evt) begin
            line_flip_d = 1'b0;
        end else if (line_evt) begin
            line_flip_d = pal_alt_q ? !line_flip_q : 1'b0;
        end

        if (!enable) begin
            state_d      = IDLE;
            burst_gate_d = 1'b0;
        end else if (hsync_start) begin
            // Restart the line from any state, including mid-burst.
            state_d      = WAIT_BURST;
            cnt_d        = 16'd1;
            burst_gate_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                WAIT_BURST: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == BURST_START_C) begin
                        state_d      = BURST;
                        burst_gate_d = 1'b1;
                    end
                end
                BURST: begin
                    if (cnt_q == BURST_END_C) begin
                        state_d      = ACTIVE;
                        burst_gate_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ACTIVE: begin
                end
                default: begin
                    state_d      = IDLE;
                    burst_gate_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= 16'd0;
            phase_inc_q      <= PHASE_INC_RESET;
            pal_alt_q        <= 1'b0;
            nco_rst_q        <= 1'b0;
            burst_gate_q     <= 1'b0;
            line_flip_q      <= 1'b0;
            cfg_ready_q      <= 1'b1;
            pend_valid_q     <= 1'b0;
            pend_phase_inc_q <= 32'd0;
            pend_pal_alt_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            phase_inc_q      <= phase_inc_d;
            pal_alt_q        <= pal_alt_d;
            nco_rst_q        <= nco_rst_d;
            burst_gate_q     <= burst_gate_d;
            line_flip_q      <= line_flip_d;
            cfg_ready_q      <= cfg_ready_d;
            pend_valid_q     <= pend_valid_d;
            pend_phase_inc_q <= pend_phase_inc_d;
            pend_pal_alt_q   <= pend_pal_alt_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign phase_inc  = phase_inc_q;
    assign nco_rst    = nco_rst_q;
    assign burst_gate = burst_gate_q;
    assign line_flip  = line_flip_q;

endmodule

// File: tb/tb_subcarrier_burst_scheduler.sv
module tb_subcarrier_burst_scheduler;

    localparam int          BS = 393;
    localparam int          BL = 187;
    localparam logic [31:0] P0 = 32'd207078536;
    localparam logic [31:0] P1 = 32'd256461247;
    localparam logic [31:0] P2 = 32'd100000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        hsync_start;
    logic        vsync_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_phase_inc;
    logic        cfg_pal_alt;
    logic [31:0] phase_inc;
    logic        nco_rst;
    logic        burst_gate;
    logic        line_flip;

    int errors = 0;
    int checks = 0;

    subcarrier_burst_scheduler #(
        .BURST_START    (BS),
        .BURST_LEN      (BL),
        .PHASE_INC_RESET(P0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .hsync_start  (hsync_start),
        .vsync_start  (vsync_start),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_phase_inc(cfg_phase_inc),
        .cfg_pal_alt  (cfg_pal_alt),
        .phase_inc    (phase_inc),
        .nco_rst      (nco_rst),
        .burst_gate   (burst_gate),
        .line_flip    (line_flip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        en;
        logic        cv;
        logic [31:0] cpi;
        logic        cpa;
        logic [31:0] e_phase;
        logic        e_nco;
        logic        e_flip;
        logic        e_ready;
        logic        e_gate;
    } vec_t;

    vec_t vecs [17];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic pulse_hs;
        hsync_start = 1'b1;
        tick();
        hsync_start = 1'b0;
    endtask

    // Called right after the hsync edge T; checks burst_gate after edges
    // T .. T+n-1 and leaves the bench just after edge T+n-1.
    task automatic check_window(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            if (k != 0) tick();
            chk($sformatf("%s_gate_k%0d", nm, k), {31'd0, burst_gate},
                {31'd0, (k >= BS && k <= BS + BL - 1)});
        end
    endtask

    initial begin
        //                hs    vs    en    cv    cpi    cpa   phase nco   flip  ready gate
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, P1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b1, 1'b1, 1'b0};
        // config in the vsync cycle: held for the next frame
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, P2,    1'b0, P1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd5, 1'b1, P1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b1, 1'b0, 1'b0};
        // disabled: vsync and hsync ignored
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, P1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, P2, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P2, 1'b0, 1'b0, 1'b1, 1'b0};
        // handshake accepted while disabled
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, P0,    1'b0, P2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, P0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, P0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; enable = 1'b0; hsync_start = 1'b0; vsync_start = 1'b0;
        cfg_valid = 1'b0; cfg_phase_inc = 32'd0; cfg_pal_alt = 1'b0;

        repeat (3) tick();
        chk("rst_phase", phase_inc, P0);
        chk("rst_nco", {31'd0, nco_rst}, 32'd0);
        chk("rst_gate", {31'd0, burst_gate}, 32'd0);
        chk("rst_flip", {31'd0, line_flip}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

        // mid-burst reset with a pending config that must be discarded
        rst_n = 1'b1; enable = 1'b1;
        tick();
        cfg_valid = 1'b1; cfg_phase_inc = 32'd123456; cfg_pal_alt = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("pend_ready", {31'd0, cfg_ready}, 32'd0);
        pulse_hs();
        repeat (399) tick();
        chk("pre_rst_gate", {31'd0, burst_gate}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gate", {31'd0, burst_gate}, 32'd0);
        chk("arst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("arst_phase", phase_inc, P0);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("idle_phase", phase_inc, P0);
            chk("idle_gate", {31'd0, burst_gate}, 32'd0);
            chk("idle_flip", {31'd0, line_flip}, 32'd0);
            chk("idle_ready", {31'd0, cfg_ready}, 32'd1);
            chk("idle_nco", {31'd0, nco_rst}, 32'd0);
        end
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
        chk("discard_phase", phase_inc, P0);
        chk("discard_nco", {31'd0, nco_rst}, 32'd1);
        tick();
        chk("discard_nco_low", {31'd0, nco_rst}, 32'd0);

        // burst window over two full lines
        pulse_hs();
        check_window(4714, "line1");
        pulse_hs();
        check_window(4714, "line2");

        // frame-aligned config
        cfg_valid = 1'b1; cfg_phase_inc = P1; cfg_pal_alt = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_phase_inc = 32'hDEADBEEF; cfg_pal_alt = 1'b0;
        chk("cfg_ready_drop", {31'd0, cfg_ready}, 32'd0);
        for (int k = 1; k < 1000; k++) begin
            tick();
            chk("cfg_wait_ready", {31'd0, cfg_ready}, 32'd0);
            chk("cfg_wait_phase", phase_inc, P0);
            chk("cfg_wait_nco", {31'd0, nco_rst}, 32'd0);
        end
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
        chk("cfg_apply_phase", phase_inc, P1);
        chk("cfg_apply_nco", {31'd0, nco_rst}, 32'd1);
        chk("cfg_apply_ready", {31'd0, cfg_ready}, 32'd1);
        chk("cfg_apply_flip", {31'd0, line_flip}, 32'd0);
        tick();
        chk("cfg_nco_low", {31'd0, nco_rst}, 32'd0);
        chk("cfg_phase_hold", phase_inc, P1);

        // PAL flip, same-cycle config/vsync, disable
        for (int i = 0; i < 17; i++) begin
            hsync_start   = vecs[i].hs;
            vsync_start   = vecs[i].vs;
            enable        = vecs[i].en;
            cfg_valid     = vecs[i].cv;
            cfg_phase_inc = vecs[i].cpi;
            cfg_pal_alt   = vecs[i].cpa;
            tick();
            chk($sformatf("vec%0d_phase", i), phase_inc, vecs[i].e_phase);
            chk($sformatf("vec%0d_nco", i), {31'd0, nco_rst}, {31'd0, vecs[i].e_nco});
            chk($sformatf("vec%0d_flip", i), {31'd0, line_flip}, {31'd0, vecs[i].e_flip});
            chk($sformatf("vec%0d_ready", i), {31'd0, cfg_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("vec%0d_gate", i), {31'd0, burst_gate}, {31'd0, vecs[i].e_gate});
        end
        hsync_start = 1'b0; vsync_start = 1'b0; enable = 1'b1; cfg_valid = 1'b0;

        // early hsync inside the burst restarts the line
        pulse_hs();
        check_window(450, "early1");
        pulse_hs();
        check_window(700, "early2");

        // disable mid-burst, hsync while disabled is ignored
        pulse_hs();
        repeat (399) tick();
        chk("dis_pre_gate", {31'd0, burst_gate}, 32'd1);
        enable = 1'b0;
        tick();
        chk("dis_gate", {31'd0, burst_gate}, 32'd0);
        pulse_hs();
        repeat (BS + 5) tick();
        chk("dis_hs_gate", {31'd0, burst_gate}, 32'd0);
        chk("dis_phase", phase_inc, P0);
        enable = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
